icache: RTL and testbench

//  Direct-mapped, read-only instruction cache between the memory controller and the instruction fetcher.

---
 rtl/icache_pkg.sv | 10 +
 rtl/icache.sv | 156 +++++++++++++++
 tb/tb_icache.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache.
package icache_pkg;

    // Refill controller states.
    typedef enum logic [0:0] {
        StIdle,
        StRefill
    } icache_state_e;

endpackage

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache. Hits return combinationally;
// misses refill one line word by word over a req/valid memory handshake.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_BITS  = 6,
    parameter int unsigned OFFSET_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy_i,
    input  logic        fetch_enable_i,
    input  logic [31:0] fetch_pc_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_inst_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_data_i
);

    localparam int unsigned NumLines = 1 << INDEX_BITS;
    localparam int unsigned NumWords = 1 << OFFSET_BITS;
    localparam int unsigned LineBits = 30 - OFFSET_BITS;
    localparam int unsigned TagBits  = LineBits - INDEX_BITS;

    localparam logic [OFFSET_BITS-1:0] CntLast = OFFSET_BITS'(NumWords - 1);
    localparam logic [OFFSET_BITS-1:0] CntOne  = OFFSET_BITS'(1);

    // Storage arrays.
    logic                valid_q [NumLines];
    logic [TagBits-1:0]  tag_q   [NumLines];
    logic [31:0]         data_q  [NumLines][NumWords];

    // Refill control state.
    icache_state_e          state_q, state_d;
    logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
    logic [LineBits-1:0]    base_q, base_d;
    logic                   mem_req_q, mem_req_d;
    logic [31:0]            mem_addr_q, mem_addr_d;

    logic                   valid_clr;
    logic                   line_fill;
    logic                   word_we;
    logic [OFFSET_BITS-1:0] cnt_nxt;

    // Fetch address split.
    logic [LineBits-1:0]    f_line;
    logic [INDEX_BITS-1:0]  f_idx;
    logic [TagBits-1:0]     f_tag;
    logic [OFFSET_BITS-1:0] f_off;
    logic [INDEX_BITS-1:0]  r_idx;
    logic [TagBits-1:0]     r_tag;
    logic                   hit;
    logic                   unused_pc;

    assign f_line    = fetch_pc_i[31:OFFSET_BITS+2];
    assign f_idx     = f_line[INDEX_BITS-1:0];
    assign f_tag     = f_line[LineBits-1:INDEX_BITS];
    assign f_off     = fetch_pc_i[OFFSET_BITS+1:2];
    assign unused_pc = ^fetch_pc_i[1:0];
    assign r_idx     = base_q[INDEX_BITS-1:0];
    assign r_tag     = base_q[LineBits-1:INDEX_BITS];
    assign cnt_nxt   = cnt_q + CntOne;

    // Hit lookup; allowed in any state, so other lines hit under a refill.
    always_comb begin
        hit          = fetch_enable_i && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        fetch_inst_o = hit ? data_q[f_idx][f_off] : 32'h0;
    end

    assign fetch_valid_o = hit;
    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = mem_addr_q;

    // Next-state logic; nothing moves while rdy_i is low.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        valid_clr  = 1'b0;
        line_fill  = 1'b0;
        word_we    = 1'b0;
        if (rdy_i) begin
            unique case (state_q)
                StIdle: begin
                    if (fetch_enable_i && !hit) begin
                        state_d    = StRefill;
                        base_d     = f_line;
                        cnt_d      = '0;
                        valid_clr  = 1'b1;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {f_line, {OFFSET_BITS{1'b0}}, 2'b00};
                    end
                end
                StRefill: begin
                    if (mem_valid_i) begin
                        word_we = 1'b1;
                        if (cnt_q != CntLast) begin
                            cnt_d      = cnt_nxt;
                            mem_addr_d = {base_q, cnt_nxt, 2'b00};
                        end else begin
                            line_fill = 1'b1;
                            mem_req_d = 1'b0;
                            state_d   = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            base_q     <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Valid bits: cleared at refill start so a partial line never hits.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NumLines; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (valid_clr) begin
            valid_q[f_idx] <= 1'b0;
        end else if (line_fill) begin
            valid_q[r_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset so they map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (!rst && line_fill) begin
            tag_q[r_idx] <= r_tag;
        end
        if (!rst && word_we) begin
            data_q[r_idx][cnt_q] <= mem_data_i;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table, hand-written
// corner sequences, then randomized traffic against a line-level model.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst, rdy, fen, mv;
    logic [31:0] fpc, mdata;
    logic        fvalid, mreq;
    logic [31:0] finst, maddr;

    always #5 clk = ~clk;

    icache dut (
        .clk           (clk),
        .rst           (rst),
        .rdy_i         (rdy),
        .fetch_enable_i(fen),
        .fetch_pc_i    (fpc),
        .fetch_valid_o (fvalid),
        .fetch_inst_o  (finst),
        .mem_req_o     (mreq),
        .mem_addr_o    (maddr),
        .mem_valid_i   (mv),
        .mem_data_i    (mdata)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: which memory line each index holds, plus refill progress.
    bit          m_valid [64];
    logic [27:0] m_line  [64];
    bit          m_busy;
    logic [27:0] m_rline;
    int          m_wcnt;
    logic [31:0] m_addr;
    bit          known;

    // Last sampled DUT outputs.
    logic        s_fv, s_req;
    logic [31:0] s_inst, s_addr;

    typedef struct {
        logic        en;
        logic [31:0] pc;
        logic        v;
        logic        fv;
        logic [31:0] inst;
        logic        req;
        logic [31:0] addr;
    } vec_t;

    vec_t vt[19];

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a << 8) | 32'h13;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive, sample, compare to model, advance model.
    task automatic cyc(input logic r, input logic d, input logic e, input logic [31:0] pc,
                       input logic v);
        logic [5:0] idx;
        bit         hit;
        @(negedge clk);
        rst   = r;
        rdy   = d;
        fen   = e;
        fpc   = pc;
        mv    = v;
        mdata = v ? (m_busy ? memword(m_addr) : 32'hDEAD_BEEF) : 32'h0;
        #1;
        s_fv   = fvalid;
        s_inst = finst;
        s_req  = mreq;
        s_addr = maddr;
        idx = pc[9:4];
        hit = e && m_valid[idx] && (m_line[idx] == pc[31:4]);
        if (known) begin
            chk("fetch_valid", {31'h0, s_fv}, {31'h0, hit});
            chk("fetch_inst", s_inst, hit ? memword({pc[31:2], 2'b00}) : 32'h0);
            chk("mem_req", {31'h0, s_req}, {31'h0, m_busy});
            chk("mem_addr", s_addr, m_addr);
        end
        if (r) begin
            for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
            m_busy = 1'b0;
            m_wcnt = 0;
            m_addr = 32'h0;
        end else if (d) begin
            if (!m_busy) begin
                if (e && !hit) begin
                    m_busy       = 1'b1;
                    m_rline      = pc[31:4];
                    m_wcnt       = 0;
                    m_valid[idx] = 1'b0;
                    m_addr       = {pc[31:4], 4'h0};
                end
            end else if (v) begin
                m_wcnt++;
                if (m_wcnt == 4) begin
                    m_busy                = 1'b0;
                    m_valid[m_rline[5:0]] = 1'b1;
                    m_line[m_rline[5:0]]  = m_rline;
                end else begin
                    m_addr = m_addr + 32'd4;
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && m_busy; k++) cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        if (m_busy) chk("drain_timeout", 32'h1, 32'h0);
    endtask

    initial begin
        logic [31:0] pc;
        rst = 1'b1; rdy = 1'b1; fen = 1'b0; fpc = 32'h0; mv = 1'b0; mdata = 32'h0;
        known = 1'b0; m_busy = 1'b0; m_wcnt = 0; m_addr = 32'h0;
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_line[i]  = '0;
        end

        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        known = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, 32'h0, 1'b0);   // reset-state outputs checked here

        // {en, pc, mem_valid, fetch_valid, fetch_inst, mem_req, mem_addr}
        vt[0]  = '{1'b1, 32'h000, 1'b0, 1'b0, 32'h0,     1'b0, 32'h000};
        vt[1]  = '{1'b1, 32'h000, 1'b1, 1'b0, 32'h0,     1'b1, 32'h000};
        vt[2]  = '{1'b1, 32'h000, 1'b0, 1'b0, 32'h0,     1'b1, 32'h004};
        vt[3]  = '{1'b1, 32'h000, 1'b1, 1'b0, 32'h0,     1'b1, 32'h004};
        vt[4]  = '{1'b1, 32'h000, 1'b1, 1'b0, 32'h0,     1'b1, 32'h008};
        vt[5]  = '{1'b1, 32'h000, 1'b1, 1'b0, 32'h0,     1'b1, 32'h00C};
        vt[6]  = '{1'b1, 32'h000, 1'b0, 1'b1, 32'h13,    1'b0, 32'h00C};
        vt[7]  = '{1'b1, 32'h004, 1'b0, 1'b1, 32'h413,   1'b0, 32'h00C};
        vt[8]  = '{1'b1, 32'h008, 1'b0, 1'b1, 32'h813,   1'b0, 32'h00C};
        vt[9]  = '{1'b1, 32'h00C, 1'b0, 1'b1, 32'hC13,   1'b0, 32'h00C};
        vt[10] = '{1'b0, 32'h000, 1'b0, 1'b0, 32'h0,     1'b0, 32'h00C};
        vt[11] = '{1'b1, 32'h400, 1'b0, 1'b0, 32'h0,     1'b0, 32'h00C};
        vt[12] = '{1'b1, 32'h000, 1'b1, 1'b0, 32'h0,     1'b1, 32'h400};
        vt[13] = '{1'b1, 32'h000, 1'b1, 1'b0, 32'h0,     1'b1, 32'h404};
        vt[14] = '{1'b1, 32'h000, 1'b1, 1'b0, 32'h0,     1'b1, 32'h408};
        vt[15] = '{1'b1, 32'h000, 1'b1, 1'b0, 32'h0,     1'b1, 32'h40C};
        vt[16] = '{1'b1, 32'h404, 1'b0, 1'b1, 32'h40413, 1'b0, 32'h40C};
        vt[17] = '{1'b1, 32'h000, 1'b0, 1'b0, 32'h0,     1'b0, 32'h40C};
        vt[18] = '{1'b0, 32'h000, 1'b0, 1'b0, 32'h0,     1'b1, 32'h000};

        for (int i = 0; i < 19; i++) begin
            cyc(1'b0, 1'b1, vt[i].en, vt[i].pc, vt[i].v);
            chk($sformatf("vec%0d_fv", i), {31'h0, s_fv}, {31'h0, vt[i].fv});
            chk($sformatf("vec%0d_inst", i), s_inst, vt[i].inst);
            chk($sformatf("vec%0d_req", i), {31'h0, s_req}, {31'h0, vt[i].req});
            chk($sformatf("vec%0d_addr", i), s_addr, vt[i].addr);
        end
        drain();

        // Redirect mid-refill: a cached line hits while another line refills.
        cyc(1'b0, 1'b1, 1'b1, 32'h100, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h100, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 32'h100, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 32'h000, 1'b0);
        chk("redirect_fv", {31'h0, s_fv}, 32'h1);
        chk("redirect_inst", s_inst, 32'h13);
        chk("redirect_addr", s_addr, 32'h108);
        cyc(1'b0, 1'b1, 1'b1, 32'h000, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 32'h000, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 32'h100, 1'b0);
        chk("redirect_after_fv", {31'h0, s_fv}, 32'h1);
        chk("redirect_after_inst", s_inst, 32'h10013);

        // rdy low for 3 cycles mid-refill; pulses during that time are lost.
        cyc(1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 1'b1, 32'h300, 1'b1);
            chk("rdylow_req", {31'h0, s_req}, 32'h1);
            chk("rdylow_addr", s_addr, 32'h204);
        end
        drain();
        cyc(1'b0, 1'b1, 1'b1, 32'h20C, 1'b0);
        chk("rdy_resume_inst", s_inst, 32'h20C13);

        // Reset after one refill word abandons the line.
        cyc(1'b0, 1'b1, 1'b1, 32'h300, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h300, 1'b0);
        chk("rst_mid_req", {31'h0, s_req}, 32'h0);
        chk("rst_mid_fv", {31'h0, s_fv}, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("rst_refetch_addr", s_addr, 32'h300);
        drain();

        // Randomized traffic over a few indices and tags to force conflicts.
        for (int n = 0; n < 3000; n++) begin
            pc = (($urandom % 4) << 10) | (($urandom % 4) << 4) | (($urandom % 4) << 2)
                 | ($urandom % 4);
            cyc(($urandom % 300) == 0, ($urandom % 8) != 0, ($urandom % 4) != 0, pc,
                m_busy ? ($urandom % 2 == 1) : ($urandom % 10 == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
